// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction fields, ALU flag and datapath controls between control unit and datapath
interface multicycle_control_unit_if #(parameter int STATE_W = 6);
  logic [5:0] opcode;
  logic [5:0] funct;
  logic zero;
  logic memWriteOrRead;
  logic pcWrite;
  logic [1:0] pcSource;
  logic irWrite;
  logic writeA;
  logic writeB;
  logic aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluControl;
  logic aluOutControl;
  logic mdrWrite;
  logic regDst;
  logic regWrite;
  logic [1:0] memToReg;
  logic halted;
  logic illegal;
  logic [STATE_W-1:0] estado;
  modport master(
    input opcode, funct, zero,
    output memWriteOrRead, pcWrite, pcSource, irWrite, writeA, writeB, aluSrcA, aluSrcB,
    aluControl, aluOutControl, mdrWrite, regDst, regWrite, memToReg, halted, illegal, estado
  );
  modport slave(
    output opcode, funct, zero,
    input memWriteOrRead, pcWrite, pcSource, irWrite, writeA, writeB, aluSrcA, aluSrcB,
    aluControl, aluOutControl, mdrWrite, regDst, regWrite, memToReg, halted, illegal, estado
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle MIPS control FSM with memory wait states, branches, loads/stores, lui, j and illegal trap
module multicycle_control_unit #(
  parameter int MEM_WAIT = 1,
  parameter int STATE_W = 6
) (
  input logic clk,
  input logic reset,
  multicycle_control_unit_if.master bus
);
  localparam logic [STATE_W-1:0] sReset = 0, sFetch = 1, sFetchWait = 2, sIRWrite = 3, sDecode = 4,
    sExecR = 5, sWriteRegAlu = 6, sBranch = 7, sMemAddr = 8, sMemRead = 9, sMemReadWait = 10,
    sWriteRegMem = 11, sMemWrite = 12, sLui = 13, sJump = 14, sBreak = 15, sIllegal = 16;
  localparam logic [3:0] lastWait = 4'(MEM_WAIT - 1);
  logic [STATE_W-1:0] state, nextState, decodeTarget;
  logic [3:0] waitCnt;
  logic waitDone, isRType, inWait;
  assign waitDone = waitCnt == lastWait;
  assign inWait = state == sFetchWait || state == sMemReadWait;
  assign isRType = bus.funct == 6'h20 || bus.funct == 6'h24 || bus.funct == 6'h22 || bus.funct == 6'h26;
  // Wait counter runs only while staying in a wait state, so every entry starts at zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= sReset;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      waitCnt <= (inWait && nextState == state) ? waitCnt + 4'd1 : '0;
    end
  end
  always_comb begin
    decodeTarget = bus.opcode == 6'h00 ? (isRType ? sExecR :
                                          bus.funct == 6'h0d ? sBreak :
                                          bus.funct == 6'h00 ? sFetch : sIllegal) :
                   (bus.opcode == 6'h04 || bus.opcode == 6'h05) ? sBranch :
                   (bus.opcode == 6'h23 || bus.opcode == 6'h2b) ? sMemAddr :
                   bus.opcode == 6'h0f ? sLui :
                   bus.opcode == 6'h02 ? sJump : sIllegal;
  end
  always_comb begin
    nextState = sReset;
    case (state)
      sReset: nextState = sFetch;
      sFetch: nextState = sFetchWait;
      sFetchWait: nextState = waitDone ? sIRWrite : sFetchWait;
      sIRWrite: nextState = sDecode;
      sDecode: nextState = decodeTarget;
      sExecR: nextState = sWriteRegAlu;
      sMemAddr: nextState = bus.opcode == 6'h23 ? sMemRead : sMemWrite;
      sMemRead: nextState = sMemReadWait;
      sMemReadWait: nextState = waitDone ? sWriteRegMem : sMemReadWait;
      sWriteRegAlu, sBranch, sWriteRegMem, sMemWrite, sLui, sJump: nextState = sFetch;
      sBreak: nextState = sBreak;
      sIllegal: nextState = sIllegal;
      default: nextState = sReset;
    endcase
  end
  always_comb begin
    bus.memWriteOrRead = 1'b0;
    bus.pcWrite = 1'b0;
    bus.pcSource = 2'b00;
    bus.irWrite = 1'b0;
    bus.writeA = 1'b0;
    bus.writeB = 1'b0;
    bus.aluSrcA = 1'b0;
    bus.aluSrcB = 2'b00;
    bus.aluControl = 3'b000;
    bus.aluOutControl = 1'b0;
    bus.mdrWrite = 1'b0;
    bus.regDst = 1'b0;
    bus.regWrite = 1'b0;
    bus.memToReg = 2'b00;
    bus.halted = 1'b0;
    bus.illegal = 1'b0;
    bus.estado = state;
    case (state)
      sFetch: begin
        bus.aluSrcB = 2'b01;
        bus.aluControl = 3'b001;
      end
      sIRWrite: begin
        bus.irWrite = 1'b1;
        bus.pcWrite = 1'b1;
        bus.aluSrcB = 2'b01;
        bus.aluControl = 3'b001;
      end
      sDecode: begin
        bus.writeA = 1'b1;
        bus.writeB = 1'b1;
        bus.aluSrcB = 2'b11;
        bus.aluControl = 3'b001;
        bus.aluOutControl = 1'b1;
      end
      sExecR: begin
        bus.aluSrcA = 1'b1;
        bus.aluOutControl = 1'b1;
        bus.aluControl = bus.funct == 6'h24 ? 3'b011 :
                         bus.funct == 6'h22 ? 3'b010 :
                         bus.funct == 6'h26 ? 3'b110 : 3'b001;
      end
      sWriteRegAlu: begin
        bus.regDst = 1'b1;
        bus.regWrite = 1'b1;
      end
      sBranch: begin
        bus.aluSrcA = 1'b1;
        bus.aluControl = 3'b010;
        bus.pcSource = 2'b01;
        bus.pcWrite = bus.opcode == 6'h04 ? bus.zero : ~bus.zero;
      end
      sMemAddr: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
        bus.aluControl = 3'b001;
        bus.aluOutControl = 1'b1;
      end
      sMemReadWait: bus.mdrWrite = waitDone;
      sWriteRegMem: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 2'b01;
      end
      sMemWrite: bus.memWriteOrRead = 1'b1;
      sLui: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 2'b10;
      end
      sJump: begin
        bus.pcWrite = 1'b1;
        bus.pcSource = 2'b10;
      end
      sBreak: bus.halted = 1'b1;
      sIllegal: bus.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench checking state sequence and all controls for MEM_WAIT=1 and MEM_WAIT=3
module tb_multicycle_control_unit;
  typedef struct packed {
    logic memWriteOrRead, pcWrite;
    logic [1:0] pcSource;
    logic irWrite, writeA, writeB, aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluControl;
    logic aluOutControl, mdrWrite, regDst, regWrite;
    logic [1:0] memToReg;
    logic halted, illegal;
  } outs_t;
  typedef struct packed {
    logic [5:0] st;
    outs_t o;
  } exp_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset0 = 0, reset1 = 0, z = 0;
  logic [5:0] op = 0, fn = 0;
  exp_t q0[$], q1[$];
  int compared = 0, mismatched = 0;
  outs_t obs0, obs1;
  multicycle_control_unit_if #(.STATE_W(6)) b0();
  multicycle_control_unit_if #(.STATE_W(6)) b1();
  assign b0.opcode = op;
  assign b0.funct = fn;
  assign b0.zero = z;
  assign b1.opcode = op;
  assign b1.funct = fn;
  assign b1.zero = z;
  assign obs0 = {b0.memWriteOrRead, b0.pcWrite, b0.pcSource, b0.irWrite, b0.writeA, b0.writeB, b0.aluSrcA,
                 b0.aluSrcB, b0.aluControl, b0.aluOutControl, b0.mdrWrite, b0.regDst, b0.regWrite,
                 b0.memToReg, b0.halted, b0.illegal};
  assign obs1 = {b1.memWriteOrRead, b1.pcWrite, b1.pcSource, b1.irWrite, b1.writeA, b1.writeB, b1.aluSrcA,
                 b1.aluSrcB, b1.aluControl, b1.aluOutControl, b1.mdrWrite, b1.regDst, b1.regWrite,
                 b1.memToReg, b1.halted, b1.illegal};
  multicycle_control_unit #(.MEM_WAIT(1), .STATE_W(6)) dut0(.clk(clk), .reset(reset0), .bus(b0.master));
  multicycle_control_unit #(.MEM_WAIT(3), .STATE_W(6)) dut1(.clk(clk), .reset(reset1), .bus(b1.master));
  function automatic outs_t expOuts(logic [5:0] st, bit last);
    outs_t e = '0;
    case (st)
      1: begin e.aluSrcB = 2'b01; e.aluControl = 3'b001; end
      3: begin e.irWrite = 1; e.pcWrite = 1; e.aluSrcB = 2'b01; e.aluControl = 3'b001; end
      4: begin e.writeA = 1; e.writeB = 1; e.aluSrcB = 2'b11; e.aluControl = 3'b001; e.aluOutControl = 1; end
      5: begin
        e.aluSrcA = 1; e.aluOutControl = 1;
        e.aluControl = fn == 6'h24 ? 3'b011 : fn == 6'h22 ? 3'b010 : fn == 6'h26 ? 3'b110 : 3'b001;
      end
      6: begin e.regDst = 1; e.regWrite = 1; end
      7: begin e.aluSrcA = 1; e.aluControl = 3'b010; e.pcSource = 2'b01; e.pcWrite = op == 6'h04 ? z : !z; end
      8: begin e.aluSrcA = 1; e.aluSrcB = 2'b10; e.aluControl = 3'b001; e.aluOutControl = 1; end
      10: e.mdrWrite = last;
      11: begin e.regWrite = 1; e.memToReg = 2'b01; end
      12: e.memWriteOrRead = 1;
      13: begin e.regWrite = 1; e.memToReg = 2'b10; end
      14: begin e.pcWrite = 1; e.pcSource = 2'b10; end
      15: e.halted = 1;
      16: e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction
  task automatic pushSt(int d, logic [5:0] st, bit last = 0);
    exp_t e;
    e.st = st;
    e.o = expOuts(st, last);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic pushInstr(int d);
    int mw = d == 0 ? 1 : 3;
    pushSt(d, 1);
    for (int i = 0; i < mw; i++) pushSt(d, 2);
    pushSt(d, 3);
    pushSt(d, 4);
    case (op)
      6'h00: begin
        if (fn inside {6'h20, 6'h24, 6'h22, 6'h26}) begin pushSt(d, 5); pushSt(d, 6); end
        else if (fn == 6'h0d) pushSt(d, 15);
        else if (fn != 6'h00) pushSt(d, 16);
      end
      6'h04, 6'h05: pushSt(d, 7);
      6'h23: begin
        pushSt(d, 8);
        pushSt(d, 9);
        for (int i = 0; i < mw; i++) pushSt(d, 10, i == mw - 1);
        pushSt(d, 11);
      end
      6'h2b: begin pushSt(d, 8); pushSt(d, 12); end
      6'h0f: pushSt(d, 13);
      6'h02: pushSt(d, 14);
      default: pushSt(d, 16);
    endcase
  endtask
  task automatic check(int d);
    exp_t e;
    logic [5:0] est;
    outs_t o;
    if (d == 0) begin
      if (q0.size() == 0) return;
      e = q0.pop_front();
      est = b0.estado;
      o = obs0;
    end else begin
      if (q1.size() == 0) return;
      e = q1.pop_front();
      est = b1.estado;
      o = obs1;
    end
    compared++;
    assert (est === e.st) else begin
      mismatched++;
      $error("FAIL estado dut%0d op=%h fn=%h: observed %0d expected %0d", d, op, fn, est, e.st);
    end
    compared++;
    assert (o === e.o) else begin
      mismatched++;
      $error("FAIL outputs dut%0d state=%0d op=%h fn=%h: observed %h expected %h", d, e.st, op, fn, o, e.o);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
    check(0);
    check(1);
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && (q0.size() > 0 || q1.size() > 0); i++) cycle();
    if (q0.size() > 0 || q1.size() > 0) begin
      compared++;
      mismatched++;
      $error("FAIL drain: observed %0d/%0d pending expected 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask
  task automatic startTest(int d);
    if (d == 0) reset0 = 0;
    else reset1 = 0;
    pushSt(d, 0);
    drain();
    if (d == 0) reset0 = 1;
    else reset1 = 1;
  endtask
  task automatic runOnce(int d, logic [5:0] o, logic [5:0] f, logic zz);
    op = o;
    fn = f;
    z = zz;
    startTest(d);
    pushInstr(d);
    pushSt(d, 1);
    drain();
  endtask
  initial begin
    cycle();
    cycle();
    op = 6'h00; fn = 6'h20; z = 0;
    startTest(0);
    pushInstr(0);
    pushInstr(0);
    pushSt(0, 1);
    drain();
    runOnce(0, 6'h00, 6'h24, 0);
    runOnce(0, 6'h00, 6'h22, 0);
    runOnce(0, 6'h00, 6'h26, 0);
    runOnce(0, 6'h00, 6'h00, 0);
    runOnce(0, 6'h04, 6'h11, 1);
    runOnce(0, 6'h04, 6'h11, 0);
    runOnce(0, 6'h05, 6'h11, 0);
    runOnce(0, 6'h05, 6'h11, 1);
    runOnce(0, 6'h2b, 6'h04, 0);
    runOnce(0, 6'h23, 6'h04, 0);
    runOnce(0, 6'h0f, 6'h00, 0);
    runOnce(0, 6'h02, 6'h00, 0);
    op = 6'h00; fn = 6'h0d;
    startTest(0);
    pushInstr(0);
    repeat (20) pushSt(0, 15);
    drain();
    reset0 = 0;
    pushSt(0, 0);
    drain();
    reset0 = 1;
    pushSt(0, 1);
    drain();
    op = 6'h3f; fn = 6'h20;
    startTest(0);
    pushInstr(0);
    repeat (5) pushSt(0, 16);
    drain();
    reset0 = 0;
    pushSt(0, 0);
    drain();
    op = 6'h00; fn = 6'h3f;
    startTest(0);
    pushInstr(0);
    repeat (3) pushSt(0, 16);
    drain();
    op = 6'h23; fn = 6'h00;
    startTest(1);
    pushInstr(1);
    pushInstr(1);
    pushSt(1, 1);
    drain();
    startTest(1);
    pushSt(1, 1);
    pushSt(1, 2);
    pushSt(1, 2);
    drain();
    reset1 = 0;
    pushSt(1, 0);
    drain();
    reset1 = 1;
    pushInstr(1);
    pushSt(1, 1);
    drain();
    runOnce(1, 6'h00, 6'h26, 0);
    runOnce(1, 6'h2b, 6'h00, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
